// File: rtl/spart_echo_driver.sv
// spart_echo_driver: programs the SPART baud divisor from br_cfg, then echoes every
// received byte back to the transmitter through a small FIFO.
module spart_echo_driver #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_CFG0   = 16'h028A,
    parameter logic [15:0] DIV_CFG1   = 16'h0145,
    parameter logic [15:0] DIV_CFG2   = 16'h00A2,
    parameter logic [15:0] DIV_CFG3   = 16'h0050
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] br_cfg_i,
    output logic       iocs_o,
    output logic       iorw_o,
    output logic [1:0] ioaddr_o,
    inout  wire  [7:0] databus_io,
    input  logic       rda_i,
    input  logic       tbr_i,
    output logic       ovf_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {RST_WAIT, INIT_DBL, INIT_DBH, IDLE, RD_RX, WR_TX, GAP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync1_q, sync2_q, cfg_last_q, cfg_used_q, ioaddr_q;
    logic [7:0]    div_hi_q, dout_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          iocs_q, iorw_q, ovf_q;
    logic [15:0]   cfg_div;
    logic          full, empty;

    assign cfg_div = sync2_q == 2'd0 ? DIV_CFG0 :
                     sync2_q == 2'd1 ? DIV_CFG1 :
                     sync2_q == 2'd2 ? DIV_CFG2 : DIV_CFG3;
    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_WAIT:               state_d = INIT_DBL;
            INIT_DBL:               state_d = INIT_DBH;
            INIT_DBH, RD_RX, WR_TX: state_d = GAP;
            GAP:                    state_d = IDLE;
            IDLE:                   state_d = sync2_q != cfg_last_q ? INIT_DBL :
                                              rda_i ? RD_RX :
                                              (tbr_i && !empty) ? WR_TX : IDLE;
            default:                state_d = RST_WAIT;
        endcase
    end

    // Bus outputs are registered from the next state so they stay a pure function of state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RST_WAIT;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cfg_last_q <= '0;
            cfg_used_q <= '0;
            div_hi_q   <= '0;
            dout_q     <= '0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= '0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= br_cfg_i;
            sync2_q  <= sync1_q;
            iocs_q   <= state_d inside {INIT_DBL, INIT_DBH, RD_RX, WR_TX};
            iorw_q   <= !(state_d inside {INIT_DBL, INIT_DBH, WR_TX});
            ioaddr_q <= state_d == INIT_DBL ? 2'b10 : state_d == INIT_DBH ? 2'b11 : 2'b00;
            dout_q   <= state_d == INIT_DBL ? cfg_div[7:0] :
                        state_d == INIT_DBH ? div_hi_q : mem_q[rptr_q];
            if (state_d == INIT_DBL) begin
                cfg_used_q <= sync2_q;
                div_hi_q   <= cfg_div[15:8];
            end
            if (state_q == INIT_DBH)
                cfg_last_q <= cfg_used_q;
            if (state_q == RD_RX && full)
                ovf_q <= 1'b1;
            if (state_q == RD_RX && !full) begin
                mem_q[wptr_q] <= databus_io;
                wptr_q        <= wptr_q + 1'b1;
                cnt_q         <= cnt_q + 1'b1;
            end
            if (state_q == WR_TX) begin
                rptr_q <= rptr_q + 1'b1;
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    assign iocs_o     = iocs_q;
    assign iorw_o     = iorw_q;
    assign ioaddr_o   = ioaddr_q;
    assign ovf_o      = ovf_q;
    assign databus_io = (iocs_q && !iorw_q) ? dout_q : 8'bz;
endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver: directed scenarios against a bus scoreboard; a small SPART model
// answers reads and records divisor writes.
module tb_spart_echo_driver;
    logic       clk = 1'b0, rst_n = 1'b0, rda = 1'b0, tbr = 1'b0;
    logic [1:0] br_cfg = 2'b00;
    logic [7:0] rx_data = 8'h00;
    logic       iocs, iorw, ovf;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    int         checks = 0, failures = 0, cyc = 0;
    int         n_rd = 0, n_wr = 0, last_rd = 0, last_wr = 0;
    logic [15:0] div_buf = 16'h0000;

    typedef struct packed {logic rd; logic [1:0] addr; logic [7:0] data;} acc_t;
    acc_t exp_q[$];
    acc_t mon_a, mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign databus = (iocs && iorw) ? rx_data : 8'bz;

    spart_echo_driver dut (
        .clk_i(clk), .rst_ni(rst_n), .br_cfg_i(br_cfg),
        .iocs_o(iocs), .iorw_o(iorw), .ioaddr_o(ioaddr), .databus_io(databus),
        .rda_i(rda), .tbr_i(tbr), .ovf_o(ovf)
    );

    // Bus monitor: every access must match the oldest expected access.
    always begin
        @(posedge clk);
        #1;
        if (iocs) begin
            mon_a = '{iorw, ioaddr, databus};
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_access got=%h", mon_a);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                assert (mon_a === mon_e) else begin
                    failures++;
                    $error("FAIL bus_access got=%h exp=%h", mon_a, mon_e);
                end
            end
            if (iorw) begin
                n_rd++;
                last_rd = cyc;
            end else begin
                n_wr++;
                last_wr = cyc;
                if (ioaddr == 2'b10) div_buf[7:0] = databus;
                if (ioaddr == 2'b11) div_buf[15:8] = databus;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_acc(logic rd, logic [1:0] a, logic [7:0] d);
        exp_q.push_back('{rd, a, d});
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Present a byte with rda until the driver reads it, then drop rda.
    task automatic rx(logic [7:0] b);
        int n0 = n_rd;
        int n  = 0;
        rx_data = b;
        rda = 1'b1;
        while (n_rd == n0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rx_seen", 32'(n_rd != n0), 32'd1);
        rda = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0, w0, n;
        // 1: reset state and initial divisor programming
        tick(3);
        chk("rst_iocs", 32'(iocs), 32'd0);
        chk("rst_iorw", 32'(iorw), 32'd1);
        chk("rst_ioaddr", 32'(ioaddr), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        expect_acc(1'b0, 2'b10, 8'h8A);
        expect_acc(1'b0, 2'b11, 8'h02);
        rst_n = 1'b1;
        drain("init0_drain", 20);
        chk("init0_div", 32'(div_buf), 32'h028A);
        // 2: baud change reprograms once
        tick(4);
        w0 = n_wr;
        t0 = cyc;
        br_cfg = 2'b01;
        expect_acc(1'b0, 2'b10, 8'h45);
        expect_acc(1'b0, 2'b11, 8'h01);
        drain("cfg1_drain", 20);
        chk("cfg1_latency", 32'((last_wr - 1 - t0) <= 6), 32'd1);
        tick(12);
        chk("cfg1_div", 32'(div_buf), 32'h0145);
        chk("cfg1_writes", 32'(n_wr - w0), 32'd2);
        // 3: single echo with latency
        tbr = 1'b1;
        expect_acc(1'b1, 2'b00, 8'hA5);
        expect_acc(1'b0, 2'b00, 8'hA5);
        rx(8'hA5);
        drain("echo_drain", 20);
        chk("echo_latency", 32'(last_wr - last_rd), 32'd3);
        chk("echo_ovf", 32'(ovf), 32'd0);
        // 4: overflow drops the fifth byte
        tbr = 1'b0;
        tick(2);
        for (int i = 1; i <= 5; i++) begin
            expect_acc(1'b1, 2'b00, 8'(i));
            rx(8'(i));
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        for (int i = 1; i <= 4; i++) expect_acc(1'b0, 2'b00, 8'(i));
        tbr = 1'b1;
        drain("ovf_drain", 40);
        tick(10);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        // 5: rda and tbr together, read wins
        tbr = 1'b0;
        tick(2);
        expect_acc(1'b1, 2'b00, 8'h11);
        rx(8'h11);
        expect_acc(1'b1, 2'b00, 8'h22);
        expect_acc(1'b0, 2'b00, 8'h11);
        expect_acc(1'b0, 2'b00, 8'h22);
        tbr = 1'b1;
        rx(8'h22);
        drain("prio_drain", 30);
        // 6: reset in the middle of a write
        br_cfg = 2'b00;
        expect_acc(1'b0, 2'b10, 8'h8A);
        expect_acc(1'b0, 2'b11, 8'h02);
        drain("cfg0_drain", 20);
        chk("cfg0_div", 32'(div_buf), 32'h028A);
        tbr = 1'b0;
        tick(2);
        expect_acc(1'b1, 2'b00, 8'h33);
        rx(8'h33);
        expect_acc(1'b1, 2'b00, 8'h44);
        rx(8'h44);
        expect_acc(1'b0, 2'b00, 8'h33);
        w0 = n_wr;
        n = 0;
        tbr = 1'b1;
        while (n_wr == w0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_seen", 32'(n_wr != w0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_iocs", 32'(iocs), 32'd0);
        chk("midrst_iorw", 32'(iorw), 32'd1);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        tick(2);
        expect_acc(1'b0, 2'b10, 8'h8A);
        expect_acc(1'b0, 2'b11, 8'h02);
        rst_n = 1'b1;
        drain("reinit_drain", 20);
        w0 = n_wr;
        tick(10);
        chk("fifo_empty", 32'(n_wr - w0), 32'd2 - 32'd2);
        expect_acc(1'b1, 2'b00, 8'h55);
        expect_acc(1'b0, 2'b00, 8'h55);
        rx(8'h55);
        drain("final_drain", 20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
